// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and round/schedule helper functions.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] c;
    } csa_t;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] shr(input logic [31:0] x, input logic [4:0] n);
        return x >> n;
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ shr(x, 5'd3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ shr(x, 5'd10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // 32-bit 3:2 compressor; the carry out of bit 31 is dropped (mod 2^32)
    function automatic csa_t csa32(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        csa_t r;
        r.s = x ^ y ^ z;
        r.c = ((x & y) | (x & z) | (y & z)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/sha256_csa5_tree.sv
// Five 32-bit operands reduced to a sum/carry pair through three levels of 3:2 compressors.
module sha256_csa5_tree
    import sha256_pkg::*;
(
    input  logic [31:0] i_x0,
    input  logic [31:0] i_x1,
    input  logic [31:0] i_x2,
    input  logic [31:0] i_x3,
    input  logic [31:0] i_x4,
    output logic [31:0] o_sum,
    output logic [31:0] o_carry
);

    csa_t w_l1;
    csa_t w_l2;
    csa_t w_l3;

    assign w_l1    = csa32(i_x0, i_x1, i_x2);
    assign w_l2    = csa32(w_l1.s, w_l1.c, i_x3);
    assign w_l3    = csa32(w_l2.s, w_l2.c, i_x4);
    assign o_sum   = w_l3.s;
    assign o_carry = w_l3.c;

endmodule

// File: rtl/sha256_round_ctrl.sv
// Iterative SHA-256 compression: one 512-bit block per handshake, one round per clock,
// chained from the IV or from the previously produced digest.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         block_valid,
    output logic         block_ready,
    input  logic [511:0] block_in,
    input  logic         first_block,
    output logic         busy,
    output logic         digest_valid,
    output logic [255:0] digest_out
);

    localparam logic [6:0] LAST_T = 7'(NUM_ROUNDS - 1);

    state_e       r_state;
    state_e       w_state_nxt;
    logic         r_block_ready;
    logic         r_busy;
    logic [6:0]   r_t;
    logic [31:0]  r_wk [8];
    logic [31:0]  r_hc [8];
    logic [31:0]  r_w  [16];
    logic [255:0] r_digest;
    logic         r_digest_valid;

    logic [31:0]  w_chain [8];
    logic [31:0]  w_t1_s;
    logic [31:0]  w_t1_c;
    logic [31:0]  w_t1;
    logic [31:0]  w_t2;
    logic [31:0]  w_ws_s;
    logic [31:0]  w_ws_c;
    logic [31:0]  w_wnew;

    // T1 = h + S1(e) + Ch(e,f,g) + K[t] + W[t]
    sha256_csa5_tree u_t1_tree (
        .i_x0    (r_wk[7]),
        .i_x1    (big_sigma1(r_wk[4])),
        .i_x2    (ch(r_wk[4], r_wk[5], r_wk[6])),
        .i_x3    (K[r_t[5:0]]),
        .i_x4    (r_w[0]),
        .o_sum   (w_t1_s),
        .o_carry (w_t1_c)
    );

    // Word entering the window: s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], seen from t+16
    sha256_csa5_tree u_sched_tree (
        .i_x0    (small_sigma1(r_w[14])),
        .i_x1    (r_w[9]),
        .i_x2    (small_sigma0(r_w[1])),
        .i_x3    (r_w[0]),
        .i_x4    (32'd0),
        .o_sum   (w_ws_s),
        .o_carry (w_ws_c)
    );

    assign w_t1   = w_t1_s + w_t1_c;
    assign w_t2   = big_sigma0(r_wk[0]) + maj(r_wk[0], r_wk[1], r_wk[2]);
    assign w_wnew = w_ws_s + w_ws_c;

    // Chain value selection at accept
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_chain[i] = 32'd0;
        end
        for (int i = 0; i < 8; i++) begin
            if (first_block) begin
                w_chain[i] = IV[i];
            end else begin
                w_chain[i] = r_digest[255-32*i -: 32];
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (block_valid) begin
                    w_state_nxt = ROUND;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ROUND: begin
                if (r_t == LAST_T) begin
                    w_state_nxt = FINAL;
                end else begin
                    w_state_nxt = ROUND;
                end
            end
            FINAL:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with registered ready/busy decodes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_block_ready <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_block_ready <= (w_state_nxt == IDLE);
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

    // Datapath: block load, round iteration and final feed-forward add
    always_ff @(posedge clk) begin
        if (rst) begin
            r_t            <= 7'd0;
            r_digest       <= 256'd0;
            r_digest_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_wk[i] <= 32'd0;
                r_hc[i] <= 32'd0;
            end
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (block_valid) begin
                        r_t            <= 7'd0;
                        r_digest_valid <= 1'b0;
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= block_in[511-32*i -: 32];
                        end
                        for (int i = 0; i < 8; i++) begin
                            r_hc[i] <= w_chain[i];
                            r_wk[i] <= w_chain[i];
                        end
                    end
                end
                ROUND: begin
                    r_t     <= r_t + 7'd1;
                    r_wk[0] <= w_t1 + w_t2;
                    r_wk[1] <= r_wk[0];
                    r_wk[2] <= r_wk[1];
                    r_wk[3] <= r_wk[2];
                    r_wk[4] <= r_wk[3] + w_t1;
                    r_wk[5] <= r_wk[4];
                    r_wk[6] <= r_wk[5];
                    r_wk[7] <= r_wk[6];
                    for (int i = 0; i < 15; i++) begin
                        r_w[i] <= r_w[i+1];
                    end
                    r_w[15] <= w_wnew;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        r_digest[255-32*i -: 32] <= r_hc[i] + r_wk[i];
                    end
                    r_digest_valid <= 1'b1;
                end
                default: begin
                    r_digest_valid <= r_digest_valid;
                end
            endcase
        end
    end

    assign block_ready  = r_block_ready;
    assign busy         = r_busy;
    assign digest_valid = r_digest_valid;
    assign digest_out   = r_digest;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: known-answer vectors, back-to-back chaining,
// held block_valid, mid-block reset and reset/valid collision.
module tb_sha256_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         block_valid;
    logic         block_ready;
    logic [511:0] block_in;
    logic         first_block;
    logic         busy;
    logic         digest_valid;
    logic [255:0] digest_out;

    sha256_round_ctrl #(.NUM_ROUNDS(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .block_valid  (block_valid),
        .block_ready  (block_ready),
        .block_in     (block_in),
        .first_block  (first_block),
        .busy         (busy),
        .digest_valid (digest_valid),
        .digest_out   (digest_out)
    );

    always #5 clk = ~clk;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'd0};
    localparam logic [511:0] TWO1_BLK  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO2_BLK  = {480'd0, 32'h000001c0};

    localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] TWO1_DIG  = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
    localparam logic [255:0] TWO2_DIG  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic [255:0] dig;
    } vec_t;

    typedef struct {
        logic [255:0] dig;
        int           acc;
    } exp_t;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: each rising digest_valid pops the oldest expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (digest_valid === 1'b1 && prev_v !== 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_digest: got digest_valid=1 with digest %h, expected no result", digest_out);
            end else begin
                e = sb.pop_front();
                chk("digest", digest_out, e.dig);
                chk("latency", 256'(cyc - e.acc), 256'd65);
            end
        end
        prev_v = digest_valid;
    end

    task automatic send(input logic [511:0] blk, input logic fb, input logic [255:0] dig,
                        input bit expect_it, input bit hold, output int acc);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (block_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got block_ready=%b after %0d cycles, expected 1", block_ready, n);
        end
        block_in    = blk;
        first_block = fb;
        block_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        chk("accept_busy", {255'd0, busy}, 256'd1);
        if (expect_it) begin
            e.dig = dig;
            e.acc = acc;
            sb.push_back(e);
        end
        if (!hold) begin
            @(negedge clk);
            block_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || block_ready !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int   acc;
        int   n;
        bit   stayed_busy;

        vecs[0] = '{ABC_BLK,   1'b1, ABC_DIG};
        vecs[1] = '{EMPTY_BLK, 1'b1, EMPTY_DIG};
        vecs[2] = '{TWO1_BLK,  1'b1, TWO1_DIG};
        vecs[3] = '{TWO2_BLK,  1'b0, TWO2_DIG};

        rst         = 1'b1;
        block_valid = 1'b0;
        first_block = 1'b0;
        block_in    = 512'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  {255'd0, block_ready},  256'd1);
        chk("rst_busy",   {255'd0, busy},         256'd0);
        chk("rst_valid",  {255'd0, digest_valid}, 256'd0);
        chk("rst_digest", digest_out,             256'd0);
        @(negedge clk);
        rst = 1'b0;

        // Known answers, back-to-back; the last two form the chained two-block message
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].blk, vecs[i].first, vecs[i].dig, 1'b1, 1'b0, acc);
        end
        wait_drain();
        repeat (5) @(negedge clk);
        chk("hold_valid",  {255'd0, digest_valid}, 256'd1);
        chk("hold_digest", digest_out,             TWO2_DIG);

        // block_valid held through busy with a different block queued behind it
        send(ABC_BLK, 1'b1, ABC_DIG, 1'b1, 1'b1, acc);
        block_in    = EMPTY_BLK;
        first_block = 1'b1;
        stayed_busy = 1'b1;
        n = 0;
        @(negedge clk);
        while (block_ready !== 1'b1 && n < 200) begin
            if (busy !== 1'b1) stayed_busy = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("held_busy",      {255'd0, stayed_busy}, 256'd1);
        chk("held_ready_gap", 256'(cyc - acc),       256'd65);
        begin
            exp_t e;
            @(posedge clk);
            #1;
            e.dig = EMPTY_DIG;
            e.acc = cyc;
            sb.push_back(e);
            chk("held_accept", {255'd0, busy}, 256'd1);
        end
        @(negedge clk);
        block_valid = 1'b0;
        wait_drain();

        // Reset in the middle of a block
        send(ABC_BLK, 1'b1, ABC_DIG, 1'b0, 1'b0, acc);
        repeat (28) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready",  {255'd0, block_ready},  256'd1);
        chk("midrst_busy",   {255'd0, busy},         256'd0);
        chk("midrst_valid",  {255'd0, digest_valid}, 256'd0);
        chk("midrst_digest", digest_out,             256'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        chk("midrst_no_result", {255'd0, digest_valid}, 256'd0);
        send(ABC_BLK, 1'b1, ABC_DIG, 1'b1, 1'b0, acc);
        wait_drain();

        // rst and block_valid together: rst wins
        @(negedge clk);
        rst         = 1'b1;
        block_valid = 1'b1;
        block_in    = ABC_BLK;
        first_block = 1'b1;
        @(posedge clk);
        #1;
        chk("collide_busy",  {255'd0, busy},        256'd0);
        chk("collide_ready", {255'd0, block_ready}, 256'd1);
        @(negedge clk);
        rst         = 1'b0;
        block_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("collide_busy2", {255'd0, busy},         256'd0);
        chk("collide_valid", {255'd0, digest_valid}, 256'd0);
        chk("collide_digest", digest_out,            256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
